// File: rtl/tempsens_avg.sv
// tempsens_avg: sliding-window moving average of calibrated temperature
// results. Keeps the last 2**LOG2_DEPTH samples in a circular buffer and a
// running sum, and publishes the rounded average once the window is full.
//
// Optional feature macro: TEMPSENS_MINMAX_EN
//   defined   -> o_min/o_max track the running min/max since reset/clear
//   undefined -> o_min tied to all ones, o_max tied to zero (no comparators)
//
// Handshake: i_valid is a single-cycle strobe with no ready/back-pressure;
// every cycle with i_valid=1 is an accept unless reset or i_clear is also
// high in that cycle (reset > i_clear > i_valid), so back-to-back strobes are
// each taken without stalling.

module tempsens_avg #(
    parameter int N_VDAC     = 7,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_VDAC-1:0]     i_res,
    input  logic                  i_valid,
    input  logic                  i_clear,
    output logic [N_VDAC-1:0]     o_avg,
    output logic                  o_avg_valid,
    output logic                  o_full,
    output logic [LOG2_DEPTH:0]   o_fill,
    output logic [N_VDAC-1:0]     o_min,
    output logic [N_VDAC-1:0]     o_max
);

    localparam int W   = 1 << LOG2_DEPTH;
    localparam int SW  = N_VDAC + LOG2_DEPTH;  // accumulator width
    localparam int SWE = SW + 1;               // rounding headroom width

    localparam logic [LOG2_DEPTH:0] W_FILL    = (LOG2_DEPTH+1)'(W);
    localparam logic [LOG2_DEPTH:0] W_FILL_M1 = (LOG2_DEPTH+1)'(W - 1);
    localparam logic [SWE-1:0]      HALF      = SWE'(W / 2);

    logic [N_VDAC-1:0]     buf_mem [W];
    logic [LOG2_DEPTH-1:0] wptr;
    logic [LOG2_DEPTH:0]   fill;
    logic [SW-1:0]         sum;
    logic [N_VDAC-1:0]     avg_q;
    logic                  avg_valid_q;

    logic                  full;
    logic                  accept;
    logic                  load_avg;
    logic [N_VDAC-1:0]     oldest;
    logic [SWE-1:0]        sum_new;
    logic [SWE-1:0]        sum_rnd;
    logic [N_VDAC-1:0]     avg_next;
    logic                  unused_bits;

    assign full     = (fill == W_FILL);
    assign accept   = i_valid && !i_clear;
    // The window is full after this accept if it already was, or if this
    // sample is the W-th one.
    assign load_avg = full || (fill == W_FILL_M1);
    assign oldest   = buf_mem[wptr];

    // Next accumulator value and its rounded average.
    always_comb begin
        sum_new  = {1'b0, sum} + SWE'(i_res);
        if (full) begin
            sum_new = sum_new - SWE'(oldest);
        end
        sum_rnd  = sum_new + HALF;
        avg_next = sum_rnd[LOG2_DEPTH +: N_VDAC];
    end

    // Bits that are provably zero or discarded by the shift.
    assign unused_bits = ^{sum_new[SWE-1], sum_rnd[SWE-1], sum_rnd[LOG2_DEPTH-1:0]};

    // Sample storage: contents are don't-care after reset/clear, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            buf_mem[wptr] <= i_res;
        end
    end

    // Pointer, fill, accumulator and registered average.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            wptr        <= '0;
            fill        <= '0;
            sum         <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (i_valid) begin
                wptr <= wptr + 1'b1;
                sum  <= sum_new[SW-1:0];
                if (!full) begin
                    fill <= fill + 1'b1;
                end
                if (load_avg) begin
                    avg_q       <= avg_next;
                    avg_valid_q <= 1'b1;
                end
            end
        end
    end

    assign o_avg       = avg_q;
    assign o_avg_valid = avg_valid_q;
    assign o_full      = full;
    assign o_fill      = fill;

`ifdef TEMPSENS_MINMAX_EN
    logic [N_VDAC-1:0] min_q;
    logic [N_VDAC-1:0] max_q;

    // Running extremes of accepted samples since reset/clear.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            min_q <= '1;
            max_q <= '0;
        end else if (i_valid) begin
            if (i_res < min_q) begin
                min_q <= i_res;
            end
            if (i_res > max_q) begin
                max_q <= i_res;
            end
        end
    end

    assign o_min = min_q;
    assign o_max = max_q;
`else
    assign o_min = '1;
    assign o_max = '0;
`endif

endmodule

// File: tb/tb_tempsens_avg.sv
// tb_tempsens_avg: directed bench for tempsens_avg (W = 8, 7-bit samples).
// A queue-based window model predicts every output each cycle; a few literal
// expectations from hand arithmetic pin the model as well.

module tb_tempsens_avg;

    localparam int N_VDAC     = 7;
    localparam int LOG2_DEPTH = 3;
    localparam int W          = 1 << LOG2_DEPTH;
`ifdef TEMPSENS_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic [N_VDAC-1:0]   i_res;
    logic                i_valid;
    logic                i_clear;
    logic [N_VDAC-1:0]   o_avg;
    logic                o_avg_valid;
    logic                o_full;
    logic [LOG2_DEPTH:0] o_fill;
    logic [N_VDAC-1:0]   o_min;
    logic [N_VDAC-1:0]   o_max;

    tempsens_avg #(.N_VDAC(N_VDAC), .LOG2_DEPTH(LOG2_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_res      (i_res),
        .i_valid    (i_valid),
        .i_clear    (i_clear),
        .o_avg      (o_avg),
        .o_avg_valid(o_avg_valid),
        .o_full     (o_full),
        .o_fill     (o_fill),
        .o_min      (o_min),
        .o_max      (o_max)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    logic [N_VDAC-1:0] win_q[$];   // samples currently in the window, oldest first
    int exp_avg   = 0;
    int exp_valid = 0;
    int exp_min   = (1 << N_VDAC) - 1;
    int exp_max   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window semantics: mean of the last W samples, rounded half up.
    task automatic model_step(input bit rst, input bit v, input bit c, input int r);
        int s;
        if (rst || c) begin
            win_q.delete();
            exp_avg   = 0;
            exp_valid = 0;
            exp_min   = (1 << N_VDAC) - 1;
            exp_max   = 0;
        end else begin
            exp_valid = 0;
            if (v) begin
                win_q.push_back(N_VDAC'(r));
                if (win_q.size() > W) void'(win_q.pop_front());
                if (win_q.size() == W) begin
                    s = 0;
                    foreach (win_q[k]) s += int'(win_q[k]);
                    exp_avg   = (s + W / 2) / W;
                    exp_valid = 1;
                end
                if (MINMAX) begin
                    if (r < exp_min) exp_min = r;
                    if (r > exp_max) exp_max = r;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit rst, input bit v, input bit c, input int r);
        reset   = rst;
        i_valid = v;
        i_clear = c;
        i_res   = N_VDAC'(r);
        @(posedge clk);
        model_step(rst, v, c, r);
        @(negedge clk);
    endtask

    task automatic accept_n(input int n, input int r);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, r);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("fill",      int'(o_fill),      win_q.size());
            chk("full",      int'(o_full),      (win_q.size() == W) ? 1 : 0);
            chk("avg",       int'(o_avg),       exp_avg);
            chk("avg_valid", int'(o_avg_valid), exp_valid);
            chk("min",       int'(o_min),       exp_min);
            chk("max",       int'(o_max),       exp_max);
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; i_valid = 1'b0; i_clear = 1'b0; i_res = '0;
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        check_en = 1'b1;
        chk("rst_fill", int'(o_fill), 0);
        chk("rst_avg",  int'(o_avg),  0);
        chk("rst_min",  int'(o_min),  127);
        chk("rst_max",  int'(o_max),  0);
        cycle(1'b0, 1'b0, 1'b0, 0);

        // Fill with 10s: single valid pulse on the 8th accept.
        accept_n(7, 10);
        chk("fill7_valid", int'(o_avg_valid), 0);
        chk("fill7_full",  int'(o_full),      0);
        accept_n(1, 10);
        chk("fill8_avg",   int'(o_avg),       10);
        chk("fill8_valid", int'(o_avg_valid), 1);
        chk("fill8_full",  int'(o_full),      1);
        chk("fill8_fill",  int'(o_fill),      8);
        cycle(1'b0, 1'b0, 1'b0, 0);
        chk("idle_valid",  int'(o_avg_valid), 0);
        chk("idle_avg",    int'(o_avg),       10);

        // Slide in 18: sum 88, avg (88+4)>>3 = 11.
        accept_n(1, 18);
        chk("slide_avg",   int'(o_avg),  11);
        chk("slide_fill",  int'(o_fill), 8);

        // Max-scale window, then drain to zero.
        accept_n(8, 127);
        chk("max_avg", int'(o_avg), 127);
        accept_n(8, 0);
        chk("zero_avg", int'(o_avg), 0);

        // Strobe together with clear: sample dropped, everything flushed.
        cycle(1'b0, 1'b1, 1'b1, 50);
        chk("clr_fill",  int'(o_fill),      0);
        chk("clr_valid", int'(o_avg_valid), 0);
        chk("clr_min",   int'(o_min),       127);
        chk("clr_max",   int'(o_max),       0);

        // Min/max tracking.
        accept_n(1, 40);
        accept_n(1, 12);
        accept_n(1, 99);
        accept_n(1, 55);
        chk("mm_min", int'(o_min), MINMAX ? 12 : 127);
        chk("mm_max", int'(o_max), MINMAX ? 99 : 0);

        // Reset mid-stream after 5 accepts, then refill across the wrap.
        accept_n(1, 70);
        cycle(1'b1, 1'b0, 1'b0, 0);
        chk("mrst_fill", int'(o_fill), 0);
        chk("mrst_avg",  int'(o_avg),  0);
        chk("mrst_full", int'(o_full), 0);
        accept_n(8, 3);
        chk("wrap_avg",  int'(o_avg),  3);
        chk("wrap_fill", int'(o_fill), 8);
        // Sum 24 - 3 + 11 = 32 -> (32+4)>>3 = 4.
        accept_n(1, 11);
        chk("wrap2_avg", int'(o_avg), 4);

        // Mixed back-to-back run with gaps, checked by the model.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, (i % 3) != 2, 1'b0, (i * 37 + 5) % 128);
        end
        cycle(1'b0, 1'b0, 1'b0, 0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
